// File: rtl/decode_issue_sched.sv
// decode_issue_sched: scoreboard-gated issue from decode into execute, with an in-flight cap.
// Optional ISSUE_WB_BYPASS_EN lets a reader issue in the same cycle its last pending writer retires.
package decode_issue_sched_pkg;
    typedef enum logic [3:0] {
        RALUOp, RWOp, IALUOp, ILOADOp, IjalrOp, IWOp,
        BOp, SOp, UluiOp, UauipcOp, JjalOp
    } decode_op_t;
endpackage

module decode_issue_sched
    import decode_issue_sched_pkg::*;
#(
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  decode_op_t       op,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       rd,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             wb_we,
    input  logic             flush,
    output logic [CNT_W-1:0] inflight,
    output logic [31:0]      stall_cycles,
    output logic             err
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] cnt [32];
    logic             live;
    logic             use_rs1, use_rs2, writes_rd;
    logic             wb_dec, inc;
    logic             byp1, byp2, haz1, haz2, full, issue;

    always_comb begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        writes_rd = 1'b1;
        case (op)
            IALUOp, ILOADOp, IjalrOp, IWOp: use_rs2 = 1'b0;
            BOp, SOp:                       writes_rd = 1'b0;
            UluiOp, UauipcOp, JjalOp: begin
                use_rs1 = 1'b0;
                use_rs2 = 1'b0;
            end
            default: ;
        endcase
    end

    assign wb_dec = wb_valid & wb_we & (wb_rd != 5'd0);

`ifdef ISSUE_WB_BYPASS_EN
    // The last pending write to the source retires now; execute forwards it from writeback.
    assign byp1 = wb_dec & (wb_rd == rs1) & (cnt[rs1] == ONE);
    assign byp2 = wb_dec & (wb_rd == rs2) & (cnt[rs2] == ONE);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign haz1  = use_rs1 & (rs1 != 5'd0) & (cnt[rs1] != '0) & ~byp1;
    assign haz2  = use_rs2 & (rs2 != 5'd0) & (cnt[rs2] != '0) & ~byp2;
    assign full  = (inflight == MAX_CNT) & ~wb_valid;
    assign issue = live & in_valid & ~flush & ~haz1 & ~haz2 & ~full & out_ready;
    assign inc   = issue & writes_rd & (rd != 5'd0);

    assign in_ready  = issue;
    assign out_valid = issue;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) cnt[i] <= '0;
            inflight     <= '0;
            stall_cycles <= '0;
            err          <= 1'b0;
            live         <= 1'b0;
        end else begin
            live <= 1'b1;
            if (live && in_valid && !issue)
                stall_cycles <= stall_cycles + 32'd1;

            if (issue && !wb_valid)
                inflight <= inflight + ONE;
            else if (wb_valid && !issue && inflight != '0)
                inflight <= inflight - ONE;
            if (wb_valid && inflight == '0)
                err <= 1'b1;

            // Same-register issue and retire cancel out.
            for (int i = 1; i < 32; i++) begin
                if (inc && rd == 5'(i) && !(wb_dec && wb_rd == 5'(i))) begin
                    cnt[i] <= cnt[i] + ONE;
                end else if (wb_dec && wb_rd == 5'(i) && !(inc && rd == 5'(i))) begin
                    if (cnt[i] == '0)
                        err <= 1'b1;
                    else
                        cnt[i] <= cnt[i] - ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_decode_issue_sched.sv
// Bench for decode_issue_sched: decode table, directed hazard/cap/flush/reset sequences, random run vs model.
module tb_decode_issue_sched;
    import decode_issue_sched_pkg::*;

    localparam int MAXI = 3;
    localparam int CW   = $clog2(MAXI + 1);
`ifdef ISSUE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic in_valid, in_ready, out_valid, out_ready;
    decode_op_t op;
    logic [4:0] rs1, rs2, rd, wb_rd;
    logic wb_valid, wb_we, flush, err;
    logic [CW-1:0] inflight;
    logic [31:0] stall_cycles;

    decode_issue_sched #(.MAX_INFLIGHT(MAXI)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs1(rs1), .rs2(rs2), .rd(rd), .out_valid(out_valid),
        .out_ready(out_ready), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we),
        .flush(flush), .inflight(inflight), .stall_cycles(stall_cycles), .err(err)
    );

    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;

    // Reference model: in-flight count plus a list of destination registers still awaiting writeback.
    int          m_infl;
    logic [31:0] m_stall;
    bit          m_err, m_live;
    logic [4:0]  pend[$];
    bit          last_iss;

    typedef struct {
        decode_op_t op;
        logic [4:0] rs1, rs2, rd;
        bit         exp_issue;
        bit         exp_wr;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int npend(input logic [4:0] s);
        int n = 0;
        foreach (pend[i]) if (pend[i] == s) n++;
        return n;
    endfunction

    function automatic void classify(input decode_op_t o, output bit u1, output bit u2, output bit w);
        u1 = 1; u2 = 1; w = 1;
        if (o inside {IALUOp, ILOADOp, IjalrOp, IWOp}) u2 = 0;
        else if (o inside {BOp, SOp}) w = 0;
        else if (o inside {UluiOp, UauipcOp, JjalOp}) begin u1 = 0; u2 = 0; end
    endfunction

    function automatic bit busy(input logic [4:0] s, input bit wv, input logic [4:0] wr, input bit we);
        int n;
        if (s == 0) return 0;
        n = npend(s);
        if (BYP && n == 1 && wv && we && wr == s) return 0;
        return n > 0;
    endfunction

    task automatic cyc(input bit iv, input decode_op_t o, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] d, input bit fl, input bit ordy,
                       input bit wv, input logic [4:0] wr, input bit we);
        bit u1, u2, w, haz, full, exp_issue;
        int idx;
        in_valid = iv; op = o; rs1 = r1; rs2 = r2; rd = d; flush = fl; out_ready = ordy;
        wb_valid = wv; wb_rd = wr; wb_we = we;
        classify(o, u1, u2, w);
        haz  = (u1 && busy(r1, wv, wr, we)) || (u2 && busy(r2, wv, wr, we));
        full = (m_infl == MAXI) && !wv;
        exp_issue = m_live && iv && !fl && !haz && !full && ordy;
        #1;
        chk("in_ready", in_ready, exp_issue);
        chk("out_valid", out_valid, exp_issue);
        last_iss = in_ready;
        @(posedge clk);
        if (m_live && iv && !exp_issue) m_stall = m_stall + 32'd1;
        if (wv && m_infl == 0) m_err = 1;
        m_infl = m_infl + int'(exp_issue) - int'(wv);
        if (m_infl < 0) m_infl = 0;
        if (wv && we && wr != 0) begin
            idx = -1;
            foreach (pend[i]) if (idx < 0 && pend[i] == wr) idx = i;
            if (idx < 0) m_err = 1;
            else pend.delete(idx);
        end
        if (exp_issue && w && d != 0) pend.push_back(d);
        m_live = 1;
        #1;
        chk("inflight", inflight, m_infl);
        chk("stall_cycles", stall_cycles, m_stall);
        chk("err", err, m_err);
    endtask

    task automatic idle(input bit wv, input logic [4:0] wr, input bit we);
        cyc(0, RALUOp, 0, 0, 0, 0, 1, wv, wr, we);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_stall", stall_cycles, 0);
        chk("rst_err", err, 0);
        m_infl = 0; m_stall = '0; m_err = 0; m_live = 0; pend.delete();
        in_valid = 0; op = RALUOp; rs1 = 0; rs2 = 0; rd = 0; flush = 0; out_ready = 1;
        wb_valid = 0; wb_rd = 0; wb_we = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    vec_t vt[14];
    decode_op_t ops[11] = '{RALUOp, RWOp, IALUOp, ILOADOp, IjalrOp, IWOp, BOp, SOp, UluiOp, UauipcOp, JjalOp};

    initial begin
        logic [31:0] s0;
        // x5 is pending while these are presented.
        vt[0]  = '{IALUOp,   5, 0, 9, 0, 1};
        vt[1]  = '{IALUOp,   6, 5, 9, 1, 1};
        vt[2]  = '{ILOADOp,  0, 5, 9, 1, 1};
        vt[3]  = '{IjalrOp,  5, 6, 9, 0, 1};
        vt[4]  = '{IWOp,     1, 5, 0, 1, 0};
        vt[5]  = '{BOp,      6, 5, 9, 0, 0};
        vt[6]  = '{BOp,      5, 6, 9, 0, 0};
        vt[7]  = '{SOp,      6, 7, 9, 1, 0};
        vt[8]  = '{UluiOp,   5, 5, 9, 1, 1};
        vt[9]  = '{UauipcOp, 5, 5, 9, 1, 1};
        vt[10] = '{JjalOp,   5, 5, 9, 1, 1};
        vt[11] = '{RALUOp,   6, 5, 9, 0, 1};
        vt[12] = '{RWOp,     6, 7, 9, 1, 1};
        vt[13] = '{RALUOp,   0, 0, 9, 1, 1};

        reset = 1'b1;
        #2;
        apply_reset();

        // First cycle after reset release never issues.
        cyc(1, IALUOp, 5, 0, 1, 0, 1, 0, 0, 0);
        chk("live_first", last_iss, 0);
        cyc(1, IALUOp, 5, 0, 1, 0, 1, 0, 0, 0);
        chk("live_second", last_iss, 1);
        chk("live_inflight", inflight, 1);
        idle(1, 1, 1);

        // Decode table.
        cyc(1, IALUOp, 0, 0, 5, 0, 1, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            cyc(1, vt[i].op, vt[i].rs1, vt[i].rs2, vt[i].rd, 0, 1, 0, 0, 0);
            chk($sformatf("vec%0d_issue", i), last_iss, vt[i].exp_issue);
            if (vt[i].exp_issue) begin
                cyc(1, BOp, vt[i].rd, 0, 0, 0, 1, 0, 0, 0);
                chk($sformatf("vec%0d_writes", i), last_iss, !vt[i].exp_wr);
                if (!vt[i].exp_wr) idle(1, 0, 0);
                idle(1, vt[i].rd, vt[i].exp_wr);
            end
        end
        idle(1, 5, 1);
        chk("table_drained", inflight, 0);

        // RAW stall then release via writeback.
        cyc(1, IALUOp, 0, 0, 5, 0, 1, 0, 0, 0);
        s0 = m_stall;
        for (int i = 0; i < 3; i++) begin
            cyc(1, BOp, 5, 6, 0, 0, 1, 0, 0, 0);
            chk("raw_hold", last_iss, 0);
        end
        cyc(1, BOp, 5, 6, 0, 0, 1, 1, 5, 1);
        chk("raw_wb_cycle", last_iss, BYP);
        if (!BYP) begin
            cyc(1, BOp, 5, 6, 0, 0, 1, 0, 0, 0);
            chk("raw_after_wb", last_iss, 1);
        end
        chk("raw_stall_cnt", stall_cycles, s0 + (BYP ? 32'd3 : 32'd4));
        idle(1, 0, 0);

        // x0 writer and x0 readers.
        cyc(1, UluiOp, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("x0_writer", last_iss, 1);
        cyc(1, RALUOp, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("x0_reader", last_iss, 1);
        idle(1, 0, 0);
        idle(1, 0, 0);

        // In-flight cap.
        for (int i = 1; i <= 3; i++) begin
            cyc(1, IALUOp, 0, 0, 5'(i), 0, 1, 0, 0, 0);
            chk("cap_fill", last_iss, 1);
        end
        cyc(1, IALUOp, 0, 0, 4, 0, 1, 0, 0, 0);
        chk("cap_blocked", last_iss, 0);
        cyc(1, IALUOp, 0, 0, 4, 0, 1, 1, 1, 1);
        chk("cap_swap", last_iss, 1);
        chk("cap_swap_inflight", inflight, 3);
        idle(1, 2, 1);
        idle(1, 3, 1);
        idle(1, 4, 1);

        // WAW on x7.
        cyc(1, IALUOp, 0, 0, 7, 0, 1, 0, 0, 0);
        cyc(1, IALUOp, 0, 0, 7, 0, 1, 0, 0, 0);
        chk("waw_second", last_iss, 1);
        idle(1, 7, 1);
        cyc(1, BOp, 7, 0, 0, 0, 1, 0, 0, 0);
        chk("waw_still_pending", last_iss, 0);
        cyc(1, BOp, 7, 0, 0, 0, 1, 1, 7, 1);
        chk("waw_last_wb", last_iss, BYP);
        if (!BYP) begin
            cyc(1, BOp, 7, 0, 0, 0, 1, 0, 0, 0);
            chk("waw_release", last_iss, 1);
        end
        chk("waw_err", err, 0);
        idle(1, 0, 0);

        // Flush blocks issue without touching the scoreboard.
        cyc(1, IALUOp, 0, 0, 9, 1, 1, 0, 0, 0);
        chk("flush_block", last_iss, 0);
        chk("flush_inflight", inflight, 0);
        cyc(1, BOp, 9, 0, 0, 0, 1, 0, 0, 0);
        chk("flush_no_pend", last_iss, 1);
        idle(1, 0, 0);

        // Spurious retire.
        idle(1, 3, 0);
        chk("spurious_err", err, 1);
        chk("spurious_inflight", inflight, 0);
        idle(0, 0, 0);
        chk("err_sticky", err, 1);
        apply_reset();

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            bit iv, fl, ordy, wv, we;
            logic [4:0] wr;
            iv = $urandom_range(0, 3) != 0;
            fl = $urandom_range(0, 7) == 0;
            ordy = $urandom_range(0, 3) != 0;
            wv = 0; wr = 0; we = 0;
            if (m_infl > 0 && $urandom_range(0, 2) == 0) begin
                wv = 1;
                if (pend.size() > 0 && (m_infl == pend.size() || $urandom_range(0, 1) == 1)) begin
                    wr = pend[$urandom_range(0, pend.size() - 1)];
                    we = 1;
                end else begin
                    wr = 5'($urandom_range(0, 31));
                end
            end
            cyc(iv, ops[$urandom_range(0, 10)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), fl, ordy, wv, wr, we);
        end

        // Reset in the middle of a stall.
        while (m_infl > 0) begin
            if (pend.size() > 0) idle(1, pend[0], 1);
            else idle(1, 0, 0);
        end
        cyc(1, IALUOp, 0, 0, 5, 0, 1, 0, 0, 0);
        cyc(1, BOp, 5, 6, 0, 0, 1, 0, 0, 0);
        chk("midrst_stall", last_iss, 0);
        #3;
        apply_reset();
        cyc(1, BOp, 5, 6, 0, 0, 1, 0, 0, 0);
        chk("midrst_live", last_iss, 0);
        cyc(1, BOp, 5, 6, 0, 0, 1, 0, 0, 0);
        chk("midrst_cleared", last_iss, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/decode_issue_sched.md
Name: decode_issue_sched

Overview:
- Issue scheduler for the decode stage: gates each decoded instruction into execute only when its source registers carry no pending writes.
- Keeps a per-register scoreboard of in-flight destination writes and caps the total number of in-flight instructions.
- Sits between the fetch/decode handoff (`fetch_data_t` plus the `decode_op_t` produced in decode) and the execute pipe register.
- Retirements are reported back from writeback.

Parameters:
- MAX_INFLIGHT, 3: maximum instructions issued but not yet retired (legal range 1..7).
- CNT_W, $clog2(MAX_INFLIGHT+1): width of each per-register pending counter and of `inflight`.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode holds a valid instruction.
- in_ready  out  1  instruction accepted this cycle.
- op  in  decode_op_t  decoded opcode class.
- rs1  in  5  source register 1 (raw_instr[19:15]).
- rs2  in  5  source register 2 (raw_instr[24:20]).
- rd  in  5  destination register (raw_instr[11:7]).
- out_valid  out  1  instruction issued to execute this cycle.
- out_ready  in  1  execute pipe register can accept.
- wb_valid  in  1  one instruction retires this cycle, including squashed ones.
- wb_rd  in  5  destination of the retiring instruction.
- wb_we  in  1  retiring instruction was counted as a writer at issue.
- flush  in  1  discard the instruction currently in decode.
- inflight  out  CNT_W  current in-flight count.
- stall_cycles  out  32  cycles with in_valid=1 and in_ready=0.
- err  out  1  sticky protocol error.

Behaviour:
- Operand use derived from op:
  - IALUOp, ILOADOp, IjalrOp, IWOp: rs1 used, writes rd.
  - BOp, SOp: rs1 and rs2 used, no rd.
  - UluiOp, UauipcOp, JjalOp: no sources, writes rd.
  - Every other op (R-type): rs1 and rs2 used, writes rd.
- Register x0 is never pending. A writer with rd=0 is not counted; sources of 0 never hazard.
- State:
  - cnt[1..31], CNT_W each.
  - inflight.
  - stall_cycles.
  - err.
  - live: cleared by reset, set to 1 on the first clock edge after reset deasserts.
- Hazard per used source s: cnt[s] != 0.
- full: inflight == MAX_INFLIGHT and not (wb_valid).
- issue = live & in_valid & ~flush & ~hazard & ~full & out_ready.
- in_ready = out_valid = issue. Combinational, zero-cycle latency.
- Counter update per clock edge:
  - cnt[rd] increments if issue and the instruction writes rd≠0.
  - cnt[wb_rd] decrements if wb_valid & wb_we & wb_rd≠0.
  - If both hit the same register, the net change is 0.
- inflight update: +issue, −wb_valid. Simultaneous issue and retire leaves it unchanged.
- Issue with wb_valid in the same cycle while inflight == MAX_INFLIGHT is allowed: inflight is unchanged.
- WAW: allowed. Multiple pending writes to one register stack in cnt.
- flush:
  - Only blocks issue that cycle.
  - In-flight instructions still report retirement through wb_valid; squashed writers assert wb_we=1 so the scoreboard stays balanced.
- Error conditions, which set err (sticky until reset):
  - wb_valid while inflight == 0: inflight stays at 0.
  - decrement of cnt == 0: that cnt stays at 0.
- stall_cycles increments when live & in_valid & ~in_ready, wrapping at 2^32.
- Reset (asynchronous, any time, including mid-operation):
  - All cnt, inflight, stall_cycles, err and live go to 0.
  - Outputs: in_ready=0, out_valid=0, inflight=0, stall_cycles=0, err=0.
  - Nothing issues in the first cycle after deassertion (live=0).
  - In-flight state is discarded. The pipeline is reset together with this block.

Optional Feature:
- Macro: ISSUE_WB_BYPASS_EN.
- Defined:
  - A source hazard on s is waived when cnt[s]==1 & wb_valid & wb_we & wb_rd==s.
  - Issue then happens in the retiring cycle; execute takes the operand from the writeback forwarding path.
- Undefined:
  - Strict behaviour: the instruction waits until cnt[s]==0, one cycle after the retirement.

Test Plan:
- Reset release, in_valid=1, op=IALUOp, rs1=5, all cnt 0 → in_ready=0 in the first cycle, in_ready=1 in the second, inflight 0→1.
- RAW: issue IALUOp rd=5, then BOp rs1=5 rs2=6 → BOp stalls and stall_cycles counts each held cycle.
  - BOp issues the cycle after wb_valid=1 wb_rd=5, or in the same cycle when ISSUE_WB_BYPASS_EN is defined.
- Writer to rd=0 (UluiOp), then an R-type op with rs1=0 rs2=0 → no stall, cnt unchanged.
- MAX_INFLIGHT=3: three independent issues → fourth blocked (in_ready=0).
  - Then the fourth together with wb_valid in the same cycle → issues, inflight stays 3.
- WAW on rd=7 twice, then one retire → a reader of x7 still stalls; after the second retire it issues. err stays 0.
- flush=1 with a hazard-free instruction → in_ready=0, no counters change.
- wb_valid with inflight=0 → err=1 and stays 1.
- Assert reset mid-stall → all outputs 0 immediately, counters cleared.
